// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types for the RV32I board run-control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Encoding is visible on the LEDs, so values are pinned explicitly.
    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        HALT     = 2'd1,
        STEP     = 2'd2,
        RUN      = 2'd3
    } run_state_t;

    // States in which the core clock enable is asserted.
    function automatic logic core_enabled(input run_state_t s);
        return (s == STEP) || (s == RUN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronises a raw active-low pushbutton, accepts a new level
//               only after DEBOUNCE_CYCLES consecutive disagreeing samples,
//               and emits a one-cycle pulse on each accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 level_q;
    logic                 level_d;
    logic                 level_dly_q;
    logic                 press_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Stability counter: any agreement restarts it; the final disagreeing
    // sample flips the accepted level and rearms the counter.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Synchroniser, accepted level and registered press-edge detector.
    // Everything resets to the "released" (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_n;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= level_dly_q & ~level_q;
        end
    end

    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : RESET / HALT / STEP / RUN sequencer for the single-cycle
//               RV32I core, driven from debounced board pushbuttons, with a
//               data-address store breakpoint and a retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESET_HOLD      = 16,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_run_n,
    input  logic             btn_step_n,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic             mem_we,
    input  logic [31:0]      data_adr,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    import cpu_ctrl_pkg::*;

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    run_state_t        state_q;
    run_state_t        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              bp_hit_q;
    logic              bp_hit_d;
    logic              cpu_reset_q;
    logic              cpu_en_q;
    logic              halted_q;
    logic [CNT_W-1:0]  count_q;
    logic              run_press;
    logic              step_press;
    logic              bp_match;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_run_n),
        .press (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_step_n),
        .press (step_press)
    );

    // Qualified by the registered enable so only stores that actually commit
    // can trip the breakpoint.
    assign bp_match = bp_en & mem_we & cpu_en_q & (data_adr == bp_addr);

    // Next-state logic; the breakpoint takes priority over a run pulse in RUN.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        bp_hit_d = bp_hit_q;
        case (state_q)
            RST_HOLD: begin
                if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
                    state_d = HALT;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            HALT: begin
                if (run_press) begin
                    state_d  = RUN;
                    bp_hit_d = 1'b0;
                end else if (step_press) begin
                    state_d  = STEP;
                    bp_hit_d = 1'b0;
                end
            end
            STEP: begin
                state_d = HALT;
                if (bp_match) begin
                    bp_hit_d = 1'b1;
                end
            end
            RUN: begin
                if (bp_match) begin
                    state_d  = HALT;
                    bp_hit_d = 1'b1;
                end else if (run_press) begin
                    state_d = HALT;
                end
            end
            default: state_d = RST_HOLD;
        endcase
    end

    // State register; outputs are registered from the next state so they
    // change in the same cycle as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_HOLD;
            hold_q      <= '0;
            bp_hit_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            cpu_en_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            bp_hit_q    <= bp_hit_d;
            cpu_reset_q <= (state_d == RST_HOLD);
            cpu_en_q    <= core_enabled(state_d);
            halted_q    <= (state_d == HALT);
        end
    end

    // Retired-instruction counter; wraps naturally, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (cpu_en_q) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign cpu_en      = cpu_en_q;
    assign halted      = halted_q;
    assign bp_hit      = bp_hit_q;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Self-checking bench for cpu_run_ctrl: directed scenarios with
//               literal expectations plus randomized buttons / stores, all
//               compared each cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 3;
    localparam int CW   = 4;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          btn_run_n  = 1'b1;
    logic          btn_step_n = 1'b1;
    logic          bp_en      = 1'b0;
    logic [31:0]   bp_addr    = 32'h0;
    logic          mem_we     = 1'b0;
    logic [31:0]   data_adr   = 32'h0;
    logic          cpu_reset;
    logic          cpu_en;
    logic          halted;
    logic          bp_hit;
    logic [1:0]    state;
    logic [CW-1:0] instr_count;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .RESET_HOLD      (HOLD),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_run_n   (btn_run_n),
        .btn_step_n  (btn_step_n),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .mem_we      (mem_we),
        .data_adr    (data_adr),
        .cpu_reset   (cpu_reset),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Mode numbers follow the published state values:
    // 0 reset-hold, 1 halt, 2 step, 3 run.
    // ------------------------------------------------------------------
    int m_mode, m_elapsed, m_edge, m_count;
    int m_acc_run, m_acc_step, m_len_run, m_len_step, m_last_run, m_last_step;
    bit m_en, m_bp_hit;
    int q_run[$];
    int q_step[$];

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_edge = 0; m_count = 0;
        m_acc_run = 1; m_acc_step = 1; m_len_run = 0; m_len_step = 0;
        m_last_run = -100; m_last_step = -100;
        m_en = 0; m_bp_hit = 0;
        q_run.delete(); q_step.delete();
    endtask

    // Accept a level once it has been seen DEB consecutive times against the
    // currently accepted level; remember the edge of every accepted press.
    task automatic deb(input int seen, input int edge_no, inout int acc, inout int len, inout int last);
        if (seen != acc) begin
            len++;
            if (len == DEB) begin
                acc = seen;
                len = 0;
                if (seen == 0) last = edge_no;
            end
        end else begin
            len = 0;
        end
    endtask

    task automatic model_step();
        int  s_run, s_step;
        bit  rp, sp, bp;
        m_edge++;
        // level seen by the debouncer is the raw sample from two edges ago
        s_run  = (q_run.size()  >= 2) ? q_run[q_run.size()-2]   : 1;
        s_step = (q_step.size() >= 2) ? q_step[q_step.size()-2] : 1;
        q_run.push_back(int'(btn_run_n));
        q_step.push_back(int'(btn_step_n));
        if (q_run.size()  > 2) void'(q_run.pop_front());
        if (q_step.size() > 2) void'(q_step.pop_front());
        deb(s_run,  m_edge, m_acc_run,  m_len_run,  m_last_run);
        deb(s_step, m_edge, m_acc_step, m_len_step, m_last_step);
        // pulse registered one edge after acceptance, acted upon the next
        rp = (m_last_run  == m_edge - 2);
        sp = (m_last_step == m_edge - 2);
        bp = bp_en && mem_we && m_en && (data_adr == bp_addr);
        if (m_en) m_count = (m_count + 1) % (1 << CW);
        case (m_mode)
            0: begin m_elapsed++; if (m_elapsed == HOLD) m_mode = 1; end
            1: begin
                if (rp)      begin m_mode = 3; m_bp_hit = 0; end
                else if (sp) begin m_mode = 2; m_bp_hit = 0; end
            end
            2: begin m_mode = 1; if (bp) m_bp_hit = 1; end
            default: begin
                if (bp)      begin m_mode = 1; m_bp_hit = 1; end
                else if (rp) m_mode = 1;
            end
        endcase
        m_en = (m_mode >= 2);
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [9:0] exp_v;
        logic [9:0] act_v;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            exp_v = {2'(m_mode), (m_mode == 0), m_en, (m_mode == 1), m_bp_hit, 4'(m_count)};
            act_v = {state, cpu_reset, cpu_en, halted, bp_hit, instr_count};
            check("cycle {state,rst,en,halt,bp,cnt}", 64'(act_v), 64'(exp_v));
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic wait_state(input int s, input int budget, input string name);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk); #1;
            if (state == 2'(s)) found = 1;
        end
        check(name, 64'(found), 64'd1);
        @(negedge clk);
    endtask

    // Wait for the state to leave 'from'; release all buttons on exit.
    task automatic watch(input int from, input int budget, output int seen);
        seen = -1;
        for (int i = 0; i < budget && seen < 0; i++) begin
            @(posedge clk); #1;
            if (state != 2'(from)) seen = int'(state);
        end
        btn_run_n  = 1'b1;
        btn_step_n = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int seen;
        int n;
        int rl_run;
        int rl_step;

        // Reset: three cycles of cpu_reset after release, then HALT.
        settle(3);
        rst_n = 1'b1;
        @(posedge clk); #1; check("reset_hold_c1", 64'(cpu_reset), 64'd1);
        @(posedge clk); #1; check("reset_hold_c2", 64'(cpu_reset), 64'd1);
        @(posedge clk); #1;
        check("reset_to_halt_state", 64'(state), 64'd1);
        check("reset_to_halt_flags", 64'({halted, cpu_en, instr_count}), 64'({1'b1, 1'b0, 4'd0}));
        @(negedge clk);

        // Step: held button gives exactly one enabled cycle.
        btn_step_n = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 20) btn_step_n = 1'b1;
            @(posedge clk); #1;
            if (cpu_en) n++;
        end
        check("step_single_pulse", 64'(n), 64'd1);
        check("step_count", 64'(instr_count), 64'd1);
        check("step_back_to_halt", 64'(state), 64'd1);
        @(negedge clk);

        // Debounce: a 3-cycle glitch is ignored, a real press runs.
        btn_run_n = 1'b0;
        settle(3);
        btn_run_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (state != 2'd1) n++;
        end
        check("glitch_ignored", 64'(n), 64'd0);
        @(negedge clk);
        btn_run_n = 1'b0;
        watch(1, 30, seen);
        check("press_enters_run", 64'(seen), 64'd3);
        settle(10);
        btn_run_n = 1'b0;
        watch(3, 30, seen);
        check("press_leaves_run", 64'(seen), 64'd1);
        settle(10);

        // Breakpoint in RUN, then cleared by a step.
        bp_en   = 1'b1;
        bp_addr = 32'h64;
        btn_run_n = 1'b0;
        watch(1, 30, seen);
        check("bp_run_entry", 64'(seen), 64'd3);
        @(negedge clk);
        mem_we   = 1'b1;
        data_adr = 32'h60;
        settle(3);
        data_adr = 32'h64;
        @(posedge clk); #1;
        check("bp_stop", 64'({cpu_en, halted, bp_hit}), 64'({1'b0, 1'b1, 1'b1}));
        @(negedge clk);
        mem_we = 1'b0;
        settle(10);
        btn_step_n = 1'b0;
        watch(1, 30, seen);
        check("bp_step_entry", 64'(seen), 64'd2);
        check("bp_cleared_by_step", 64'(bp_hit), 64'd0);
        settle(10);

        // Simultaneous run + step in HALT: run wins.
        btn_run_n  = 1'b0;
        btn_step_n = 1'b0;
        watch(1, 30, seen);
        check("run_beats_step", 64'(seen), 64'd3);
        settle(10);

        // Run pulse and breakpoint in the same cycle (pulse acted on 8 edges
        // after the press is first sampled).
        btn_run_n = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        mem_we   = 1'b1;
        data_adr = 32'h64;
        @(posedge clk); #1;
        check("run_and_bp_state", 64'(state), 64'd1);
        check("run_and_bp_flag", 64'(bp_hit), 64'd1);
        @(negedge clk);
        mem_we    = 1'b0;
        btn_run_n = 1'b1;
        settle(10);

        // Mid-run asynchronous reset.
        btn_run_n = 1'b0;
        watch(1, 30, seen);
        check("midrun_entry", 64'(seen), 64'd3);
        settle(3);
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({cpu_reset, cpu_en, bp_hit, instr_count}), 64'({1'b1, 1'b0, 1'b0, 4'd0}));
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap: 17 enabled cycles on a 4-bit counter read back 1.
        wait_state(1, 20, "wrap_halt");
        btn_run_n = 1'b0;
        watch(1, 30, seen);
        check("wrap_run_entry", 64'(seen), 64'd3);
        repeat (17) @(posedge clk);
        #1;
        check("wrap_count", 64'(instr_count), 64'd1);
        @(negedge clk);

        // Randomized buttons, stores and occasional resets.
        bp_addr = 32'h64;
        rl_run  = 0;
        rl_step = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if (rl_run == 0) begin
                btn_run_n = ($urandom % 3 == 0) ? 1'b0 : 1'b1;
                rl_run    = $urandom_range(1, 14);
            end else begin
                rl_run--;
            end
            if (rl_step == 0) begin
                btn_step_n = ($urandom % 3 == 0) ? 1'b0 : 1'b1;
                rl_step    = $urandom_range(1, 14);
            end else begin
                rl_step--;
            end
            mem_we   = ($urandom % 4 == 0) ? 1'b1 : 1'b0;
            data_adr = ($urandom % 3 == 0) ? bp_addr : 32'($urandom_range(0, 255));
            if (c % 250 == 0) bp_en = ($urandom % 2 == 0) ? 1'b1 : 1'b0;
            rst_n = ($urandom % 400 == 0) ? 1'b0 : 1'b1;
        end
        rst_n = 1'b1;
        settle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case something never returns.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the single-cycle RV32I core on the FPGA board. It converts the raw board pushbuttons into RESET / HALT / STEP / RUN control of `cpu_top`. The core is driven through a clock enable and a held reset. A data-address breakpoint halts the core on a matching store. The block sits in the board top, between the buttons and the processor. Its status outputs feed the LEDs.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized samples needed to accept a button level (10 ms at 50 MHz).
- `RESET_HOLD`, 16: cycles `cpu_reset` stays high after leaving reset; must be ≥1.
- `CNT_W`, 32: width of `instr_count`.

- `clk` in 1: board clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_run_n` in 1: raw active-low button, asynchronous; each press toggles RUN/HALT.
- `btn_step_n` in 1: raw active-low button, asynchronous; each press executes one instruction when halted.
- `bp_en` in 1: breakpoint enable (slide switch, treated as quasi-static).
- `bp_addr` in 32: breakpoint data address.
- `mem_we` in 1: store strobe from the core (MemWrite).
- `data_adr` in 32: data address from the core (`DataAdr`).
- `cpu_reset` out 1: active-high reset to the core.
- `cpu_en` out 1: clock enable to the core (PC/regfile/memory write qualify).
- `halted` out 1: high in HALT.
- `bp_hit` out 1: sticky; the last halt was caused by a breakpoint.
- `state` out 2: encoded FSM state, for LEDs.
- `instr_count` out `CNT_W`: number of enabled cycles (retired instructions) since reset.

## Operation
- FSM states: RST_HOLD=0, HALT=1, STEP=2, RUN=3. All outputs are registered.
- Reset values: state=RST_HOLD, `cpu_reset`=1, `cpu_en`=0, `halted`=0, `bp_hit`=0, `instr_count`=0, hold counter=0. The debouncers reset to the "released" state.
- RST_HOLD: `cpu_reset`=1 and `cpu_en`=0. After `RESET_HOLD` cycles the FSM enters HALT. Button pulses during RST_HOLD are dropped.
- HALT:
  - `cpu_en`=0, `halted`=1.
  - A run pulse goes to RUN and clears `bp_hit`.
  - A step pulse goes to STEP and clears `bp_hit`.
  - A run pulse and a step pulse in the same cycle: run wins.
- STEP: `cpu_en`=1 for exactly one cycle, then HALT unconditionally. A breakpoint match in that cycle still sets `bp_hit`.
- RUN: `cpu_en`=1 every cycle.
  - A run pulse goes to HALT.
  - A breakpoint hit goes to HALT with `bp_hit`=1. The matching store completes because `cpu_en` was high in that cycle.
  - A step pulse in RUN is ignored.
  - A run pulse and a breakpoint in the same cycle: go to HALT with `bp_hit`=1.
- Breakpoint hit = `bp_en` & `mem_we` & `cpu_en` & (`data_adr`==`bp_addr`). It is a full 32-bit compare, evaluated combinationally on the current cycle.
- `instr_count` increments in every cycle where `cpu_en`=1 and wraps from all-ones to 0. It is cleared only by `rst_n`, not by HALT.
- Button path per button:
  - 2-flop synchronizer.
  - Stability counter: counts while the synchronized level differs from the accepted level; resets to 0 on any agreement. When it reaches `DEBOUNCE_CYCLES`, the accepted level updates.
  - One-cycle pulse on the accepted press edge (high→low). Release produces no pulse.
  - A held button produces exactly one pulse.

## Timing
- Button latency: from a stable raw press to the press pulse is 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- Press pulse to FSM response: the FSM register updates in the cycle after the pulse, and `cpu_en` follows in the same cycle as the state change.
- A STEP gives exactly one cycle of `cpu_en`=1, then HALT in the next cycle.
- Breakpoint: if the store is in cycle N, then `cpu_en`=0 and `halted`=1 from cycle N+1.
- Glitches shorter than `DEBOUNCE_CYCLES` never produce a pulse.
- Asserting `rst_n` mid-operation returns all outputs to reset values immediately (asynchronously). Deassertion restarts RST_HOLD.

## Structure
- Package `cpu_ctrl_pkg` holds `typedef enum logic [1:0] {RST_HOLD, HALT, STEP, RUN} run_state_t`.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `btn_n`, `press`) is instantiated twice.

## Test plan
Test parameters: `DEBOUNCE_CYCLES`=4, `RESET_HOLD`=3.
- Reset: release `rst_n` → `cpu_reset`=1 for 3 cycles, then `state`=1, `halted`=1, `cpu_en`=0, `instr_count`=0.
- Step: hold `btn_step_n` low for 20 cycles → exactly one `cpu_en` pulse one cycle wide, `instr_count`=1, back to HALT.
- Debounce: a 3-cycle low glitch on `btn_run_n` → no state change. A 10-cycle press → RUN. A second press → HALT, with `instr_count` equal to the number of enabled cycles in between.
- Breakpoint: `bp_en`=1, `bp_addr`=0x64, RUN, drive `mem_we`=1 with `data_adr`=0x64 in cycle N → `cpu_en`=0 and `bp_hit`=1 at N+1. Then press step → `bp_hit` clears.
- Simultaneous events: run and step pulses in the same cycle in HALT → RUN. A run pulse and a breakpoint in the same cycle in RUN → HALT with `bp_hit`=1.
- Mid-run reset and wrap: assert `rst_n`=0 during RUN → `cpu_reset`=1 and `cpu_en`=0 asynchronously. Separately, with `CNT_W`=4, run for 17 cycles → `instr_count`=1.
